// File: rtl/dram_port_arbiter.sv
// Two-port round-robin burst sequencer for a single-ported DRAM.
// One beat per cycle on a registered bus; read valids are delayed RD_LAT cycles behind RD.
module dram_port_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        We0,
  input  logic        We1,
  input  logic [15:0] Addr0,
  input  logic [15:0] Addr1,
  input  logic [3:0]  Len0,
  input  logic [3:0]  Len1,
  input  logic [15:0] WData0,
  input  logic [15:0] WData1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        WAck0,
  output logic        WAck1,
  output logic        RValid0,
  output logic        RValid1,
  output logic [15:0] RData,
  output logic        Done0,
  output logic        Done1,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic [15:0] DataOut,
  input  logic [15:0] DataIn
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  len_q, len_d;
  logic        we_q, we_d;
  logic        port_q, port_d;
  logic        last_q, last_d;
  logic        win, win_we;
  // vld_pipe_q[i][p]: port p had RD high i+1 cycles ago
  logic [RD_LAT-1:0][1:0] vld_pipe_q;

  // Tie goes to the port that did not win last; otherwise the lone requester.
  assign win    = (Req0 & Req1) ? ~last_q : Req1;
  assign win_we = win ? We1 : We0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = we_q;
    port_d  = port_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (Req0 | Req1) begin
        port_d  = win;
        last_d  = win;
        we_d    = win_we;
        len_d   = win ? Len1 : Len0;
        addr_d  = win ? Addr1 : Addr0;
        rd_d    = ~win_we;
        wr_d    = win_we;
        cnt_d   = '0;
        state_d = XFER;
      end
      XFER: if (cnt_q == len_q) begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        cnt_d   = '0;
        state_d = we_q ? DONE : DRAIN;
      end else begin
        addr_d = addr_q + 16'd1;
        cnt_d  = cnt_q + 4'd1;
      end
      DRAIN: if (cnt_q == 4'(RD_LAT - 1)) state_d = DONE;
             else cnt_d = cnt_q + 4'd1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      we_q    <= we_d;
      port_q  <= port_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= {rd_q & port_q, rd_q & ~port_q};
      for (int i = 1; i < RD_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  assign Addr    = addr_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign DataOut = wr_q ? (port_q ? WData1 : WData0) : 16'h0;
  assign RData   = DataIn;
  assign Gnt0    = (state_q == XFER) && (cnt_q == 4'd0) && !port_q;
  assign Gnt1    = (state_q == XFER) && (cnt_q == 4'd0) &&  port_q;
  assign WAck0   = wr_q & ~port_q;
  assign WAck1   = wr_q &  port_q;
  assign Done0   = (state_q == DONE) && !port_q;
  assign Done1   = (state_q == DONE) &&  port_q;
  assign RValid0 = vld_pipe_q[RD_LAT-1][0];
  assign RValid1 = vld_pipe_q[RD_LAT-1][1];

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: DRAM model with RD_LAT-cycle reads, per-burst
// cycle-accurate expectations derived from the burst parameters.
module tb_dram_port_arbiter;
  localparam int LAT = 2;

  logic        Clk1, Reset;
  logic [1:0]  req, we;
  logic [15:0] addr_in [2];
  logic [3:0]  len_in  [2];
  logic [15:0] wdata   [2];
  logic        Gnt0, Gnt1, WAck0, WAck1, RValid0, RValid1, Done0, Done1, RD, WR;
  logic [15:0] RData, Addr, DataOut, DataIn;

  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] rdp     [LAT];
  logic [15:0] wdat    [2][16];
  logic        last_gnt;
  int          checks, failures;

  dram_port_arbiter #(.RD_LAT(LAT)) dut (
    .Clk1(Clk1), .Reset(Reset),
    .Req0(req[0]), .Req1(req[1]), .We0(we[0]), .We1(we[1]),
    .Addr0(addr_in[0]), .Addr1(addr_in[1]), .Len0(len_in[0]), .Len1(len_in[1]),
    .WData0(wdata[0]), .WData1(wdata[1]),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .WAck0(WAck0), .WAck1(WAck1),
    .RValid0(RValid0), .RValid1(RValid1), .RData(RData),
    .Done0(Done0), .Done1(Done1), .Addr(Addr), .RD(RD), .WR(WR),
    .DataOut(DataOut), .DataIn(DataIn)
  );

  initial begin
    Clk1 = 1'b0;
    forever #5 Clk1 = ~Clk1;
  end

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 40503) ^ 16'h1234;
  endfunction

  // DRAM: write on WR edge, read data appears LAT cycles after the RD cycle
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
    for (int i = 0; i < LAT; i++) rdp[i] = 16'h0;
    forever begin
      @(posedge Clk1);
      if (WR) mem[Addr] = DataOut;
      for (int i = LAT - 1; i > 0; i--) rdp[i] = rdp[i-1];
      rdp[0] = Addr;
    end
  end
  assign DataIn = mem[rdp[LAT-1]];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] bus_vec();
    return {Addr, RD, WR, WAck0, WAck1, Gnt0, Gnt1, RValid0, RValid1, Done0, Done1};
  endfunction

  // Wait for a grant to port p, then check every cycle through its Done.
  task automatic burst(input int p, input logic [1:0] drop, input int abort_c);
    logic [15:0] a, ea, edo;
    logic [3:0]  len;
    logic        w, eon, erv, ed, eg, got;
    logic [25:0] ev;
    int          done_c;
    a = addr_in[p]; len = len_in[p]; w = we[p];
    done_c = int'(len) + 1 + (w ? 0 : LAT);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge Clk1);
      got = Gnt0 | Gnt1;
    end
    chk("grant", 32'({Gnt1, Gnt0}), (p == 1) ? 32'd2 : 32'd1);
    if (!got) return;
    last_gnt = p[0];
    if (drop[0]) req[0] = 1'b0;
    if (drop[1]) req[1] = 1'b0;
    for (int c = 0; c <= done_c; c++) begin
      if (c > 0) @(negedge Clk1);
      if (c == abort_c) begin
        Reset = 1'b0;
        #1;
        chk("abort_strobes", 32'({WR, RD, WAck1, WAck0, Addr}), 32'd0);
        for (int k = 0; k < c; k++) ref_mem[a + 16'(k)] = wdat[p][k];
        return;
      end
      eon = (c <= int'(len));
      edo = 16'h0;
      if (eon) begin
        wdata[p] = wdat[p][c];
        if (w) edo = wdat[p][c];
      end else begin
        wdata[p] = 16'h0;
      end
      wdata[1-p] = 16'($urandom);
      #1;
      ea  = a + 16'(eon ? c : int'(len));
      erv = !w && (c >= LAT) && (c - LAT <= int'(len));
      ed  = (c == done_c);
      eg  = (c == 0);
      ev  = {ea, eon && !w, eon && w, eon && w && p == 0, eon && w && p == 1,
             eg && p == 0, eg && p == 1, erv && p == 0, erv && p == 1,
             ed && p == 0, ed && p == 1};
      chk("bus", 32'(bus_vec()), 32'(ev));
      chk("dataout", 32'(DataOut), 32'(edo));
      if (erv) chk("rdata", 32'(RData), 32'(ref_mem[a + 16'(c - LAT)]));
    end
    if (w) for (int k = 0; k <= int'(len); k++) begin
      ref_mem[a + 16'(k)] = wdat[p][k];
      chk("mem", 32'(mem[a + 16'(k)]), 32'(wdat[p][k]));
    end
  endtask

  task automatic setup(input int p, input logic w, input logic [15:0] a, input logic [3:0] l);
    we[p] = w; addr_in[p] = a; len_in[p] = l;
    for (int k = 0; k < 16; k++) wdat[p][k] = 16'($urandom);
  endtask

  initial begin
    checks = 0; failures = 0; last_gnt = 1'b1;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
    Reset = 1'b0; req = 2'b00; we = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr_in[p] = '0; len_in[p] = '0; wdata[p] = '0;
    end
    repeat (2) @(negedge Clk1);
    chk("reset_state", 32'(bus_vec()), 32'd0);

    // tie from reset, single-beat reads: 0,1,0,1
    setup(0, 1'b0, 16'h0020, 4'd0);
    setup(1, 1'b0, 16'h0030, 4'd0);
    req = 2'b11;
    @(negedge Clk1);
    Reset = 1'b1;
    burst(0, 2'b00, -1);
    burst(1, 2'b00, -1);
    burst(0, 2'b00, -1);
    burst(1, 2'b11, -1);

    // 4-beat read
    setup(0, 1'b0, 16'h0010, 4'd3); req[0] = 1'b1;
    burst(0, 2'b01, -1);

    // 16-beat write with counting data
    setup(1, 1'b1, 16'h0100, 4'd15);
    for (int k = 0; k < 16; k++) wdat[1][k] = 16'(k);
    req[1] = 1'b1;
    burst(1, 2'b10, -1);

    // address wrap
    setup(0, 1'b0, 16'hFFFE, 4'd3); req[0] = 1'b1;
    burst(0, 2'b01, -1);

    // reset during beat 5 of a 16-beat write
    setup(1, 1'b1, 16'h0200, 4'd15); req[1] = 1'b1;
    burst(1, 2'b10, 5);
    @(negedge Clk1);
    chk("in_reset", 32'(bus_vec()), 32'd0);
    Reset = 1'b1; last_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk1);
      chk("post_reset_idle", 32'(bus_vec()), 32'd0);
    end
    for (int k = 0; k < 16; k++)
      chk("abort_mem", 32'(mem[16'h0200 + 16'(k)]), 32'(ref_mem[16'h0200 + 16'(k)]));
    setup(0, 1'b0, 16'h0300, 4'd0);
    setup(1, 1'b0, 16'h0400, 4'd0);
    req = 2'b11;
    burst(0, 2'b01, -1);
    burst(1, 2'b10, -1);

    // randomized bursts, some with both ports requesting
    for (int n = 0; n < 30; n++) begin
      int p, wn;
      logic tie;
      p   = int'($urandom_range(0, 1));
      tie = ($urandom_range(0, 3) == 0);
      setup(0, 1'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
      setup(1, 1'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
      if (tie) begin
        wn = last_gnt ? 0 : 1;
        req = 2'b11;
        burst(wn, (wn == 0) ? 2'b01 : 2'b10, -1);
        burst(1 - wn, (wn == 0) ? 2'b10 : 2'b01, -1);
      end else begin
        req = (p == 1) ? 2'b10 : 2'b01;
        burst(p, req, -1);
      end
    end

    repeat (2) @(negedge Clk1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
